lc4_alu_issue: RTL and testbench
================================

# lc4_alu_issue

Issue stage that feeds `lc4_alu` with instructions and operands. It fetches 16-bit LC4 instruction words from instruction memory, decodes register selects, and captures 64-bit operands from the register file. It presents instruction, PC, operands and the multi-word carry flag to the ALU through a valid/ready handshake. It owns the carry flag chaining SDR1/SDR2 shift-right sequences across words, and accepts PC redirects from downstream branch resolution.

## Interface
- `WORD_SIZE`, 64, operand width (min 16)
- `clk` in 1: clock, rising edge
- `rst_n` in 1: reset, synchronous, active-low
- `i_start` in 1: pulse; begin fetching at `i_start_pc` (honoured only in IDLE)
- `i_start_pc` in 16: initial PC
- `i_halt` in 1: level; stop after the current issue handshake
- `i_redirect` in 1: pulse; flush and refetch at `i_redirect_pc`
- `i_redirect_pc` in 16: redirect target
- `o_imem_rd` out 1: instruction read strobe
- `o_imem_addr` out 16: instruction address
- `i_imem_data` in 16: instruction word, valid exactly 1 cycle after `o_imem_rd`
- `o_rf_r1sel`, `o_rf_r2sel` out 3 each: register file read selects
- `i_rf_r1data`, `i_rf_r2data` in WORD_SIZE: combinational register file read data
- `o_valid` out 1: issue bundle valid
- `i_ready` in 1: ALU/writeback accepts bundle
- `o_insn` out 16, `o_pc` out 16, `o_r1data`/`o_r2data` out WORD_SIZE, `o_carry` out 1: bundle fields driven to `lc4_alu`

## Operation
- States: IDLE, FETCH, DECODE, ISSUE. Not pipelined; one instruction in flight.
- IDLE: `i_start` loads `pc <= i_start_pc`, clears `carry_q`, goes to FETCH. All other inputs except `i_redirect` are ignored.
- FETCH: `o_imem_rd=1`, `o_imem_addr=pc`. Next state is DECODE.
- DECODE: `i_imem_data` is valid. It is latched into `o_insn`, and `o_pc <= pc`.
  - Selects are decoded combinationally from `i_imem_data`:
    - r1sel = insn[11:9] when opcode is 1101 (HICONST); otherwise insn[8:6].
    - r2sel = insn[11:9] when insn[15:13] is 011 (LDR/STR); otherwise insn[2:0].
  - `i_rf_r1data`/`i_rf_r2data` are registered into `o_r1data`/`o_r2data` the same cycle.
  - Next state is ISSUE.
- ISSUE: `o_valid=1`. All bundle fields are held stable until `o_valid && i_ready`. On handshake:
  - `pc <= pc + 1`, wrapping 16'hFFFF to 16'h0000.
  - Carry update:
    - SDR1 (opcode 0001, insn[5:3]=011): `carry_q <= o_r1data[0]`.
    - SDR2 (opcode 1010, insn[5:4]=11): `carry_q <= o_r2data[0]`.
    - All other instructions leave `carry_q` unchanged.
  - Next state is IDLE if `i_halt`, otherwise FETCH.
- `o_carry = carry_q`. The value issued with an SDR2 is the pre-update flag.
- `i_redirect` (any state): `pc <= i_redirect_pc`, next state FETCH. It overrides `i_halt` and `i_start`.
  - Any instruction in DECODE, or in ISSUE without a same-cycle handshake, is discarded.
  - If redirect coincides with an ISSUE handshake, the handshake completes, the carry update applies, and redirect supplies the PC.
- Read data arriving after a flush is ignored.

## Timing
- Reset values: state IDLE, `pc=0`, `carry_q=0`, `o_valid=0`, `o_imem_rd=0`, `o_imem_addr=0`. `o_insn`, `o_pc`, `o_r1data` and `o_r2data` are all 0.
- `i_start` sampled at cycle N:
  - FETCH (`o_imem_rd`=1) at N+1.
  - DECODE at N+2.
  - `o_valid=1` at N+3.
- Back-to-back throughput with `i_ready` held high: one instruction per 3 cycles.
- `o_valid` never drops without a handshake, except on reset or redirect.
- Reset mid-operation returns to reset values on the next edge, regardless of any other input.

## Structure
- Package `lc4_issue_pkg`:
  - State enum.
  - Opcode constants: OP_ARITH 4'b0001, OP_SHIFT 4'b1010, OP_CONST 4'b1001, OP_HICONST 4'b1101, LDST prefix 3'b011.
  - Sub-op constants: SUB_SDR1 3'b011, SDR2 shift code 2'b11.
- Sub-module `lc4_operand_select`: purely combinational; insn → r1sel, r2sel, is_sdr1, is_sdr2.

## Test plan
- Reset then start at 16'h0200 with `i_ready=1`: `o_imem_addr`=0200 in cycle 1, `o_valid` in cycle 3 with `o_pc`=0200, the next fetch at 0201, and one issue every 3 cycles.
- Backpressure: hold `i_ready=0` for 5 cycles in ISSUE; the bundle is stable throughout; on release exactly one handshake occurs and `pc` advances by 1.
- Carry chain: R1=64'h...0003 and SDR1 (insn 16'h1218) sets carry to 1; the following SDR2 (16'hA233) with R2=64'h...0002 issues with `o_carry`=1, then carry becomes 0.
- Register selects:
  - HICONST 16'hD6AB drives r1sel=3.
  - STR 16'h7A45 drives r1sel=1, r2sel=5.
  - ADD 16'h1443 drives r1sel=1, r2sel=3.
- Redirect: redirect to 16'h8000 asserted in DECODE drops the bundle (no `o_valid`), and the next fetch address is 8000. Redirect concurrent with an ISSUE handshake applies the carry update and fetches at 8000.
- Boundaries:
  - Start at FFFF: the next fetch address is 0000.
  - `i_halt` at handshake returns to IDLE with `o_imem_rd` staying 0.
  - `rst_n=0` in ISSUE clears `o_valid` on the next edge.

Source files
------------

// File: rtl/lc4_alu_issue_pkg.sv
// Shared types and decode constants for the LC4 issue stage.
package lc4_issue_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DECODE = 2'd2,
        ST_ISSUE  = 2'd3
    } issue_state_t;

    localparam logic [3:0] OP_ARITH   = 4'b0001;
    localparam logic [3:0] OP_SHIFT   = 4'b1010;
    localparam logic [3:0] OP_CONST   = 4'b1001;
    localparam logic [3:0] OP_HICONST = 4'b1101;
    localparam logic [2:0] OP_LDST    = 3'b011;

    localparam logic [2:0] SUB_SDR1   = 3'b011;
    localparam logic [1:0] SHIFT_SDR2 = 2'b11;

endpackage

// File: rtl/lc4_alu_issue_if.sv
// Issue bundle from the issue stage to lc4_alu with valid/ready handshake.
interface lc4_alu_issue_if #(parameter int WORD_SIZE = 64);
    logic                 valid;
    logic                 ready;
    logic [15:0]          insn;
    logic [15:0]          pc;
    logic [WORD_SIZE-1:0] r1data;
    logic [WORD_SIZE-1:0] r2data;
    logic                 carry;

    modport master (output valid, insn, pc, r1data, r2data, carry, input ready);
    modport slave  (input valid, insn, pc, r1data, r2data, carry, output ready);
endinterface

// File: rtl/lc4_alu_issue_operand_select.sv
// Combinational register-select and shift-right detection from an LC4 instruction word.
module lc4_operand_select
    import lc4_issue_pkg::*;
(
    input  logic [15:0] insn,
    output logic [2:0]  r1sel,
    output logic [2:0]  r2sel,
    output logic        is_sdr1,
    output logic        is_sdr2
);
    logic [3:0] opcode;

    assign opcode  = insn[15:12];
    assign r1sel   = (opcode == OP_HICONST) ? insn[11:9] : insn[8:6];
    assign r2sel   = (insn[15:13] == OP_LDST) ? insn[11:9] : insn[2:0];
    assign is_sdr1 = (opcode == OP_ARITH) && (insn[5:3] == SUB_SDR1);
    assign is_sdr2 = (opcode == OP_SHIFT) && (insn[5:4] == SHIFT_SDR2);
endmodule

// File: rtl/lc4_alu_issue.sv
// LC4 issue stage: fetch, decode selects, capture operands, hand bundle to lc4_alu.
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | imem read strobe out for pc
// DECODE | imem word valid, operands captured
// ISSUE  | bundle valid, waiting for ready
module lc4_alu_issue
    import lc4_issue_pkg::*;
#(
    parameter int WORD_SIZE = 64
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic [15:0]          i_start_pc,
    input  logic                 i_halt,
    input  logic                 i_redirect,
    input  logic [15:0]          i_redirect_pc,
    output logic                 o_imem_rd,
    output logic [15:0]          o_imem_addr,
    input  logic [15:0]          i_imem_data,
    output logic [2:0]           o_rf_r1sel,
    output logic [2:0]           o_rf_r2sel,
    input  logic [WORD_SIZE-1:0] i_rf_r1data,
    input  logic [WORD_SIZE-1:0] i_rf_r2data,
    lc4_alu_issue_if.master      alu
);
    issue_state_t state;
    logic [15:0]  pc;
    logic [15:0]  pc_next;
    logic         carry_q;
    logic         sdr1_q;
    logic         sdr2_q;
    logic         dec_sdr1;
    logic         dec_sdr2;

    lc4_operand_select u_sel (
        .insn    (i_imem_data),
        .r1sel   (o_rf_r1sel),
        .r2sel   (o_rf_r2sel),
        .is_sdr1 (dec_sdr1),
        .is_sdr2 (dec_sdr2)
    );

    assign pc_next   = pc + 16'd1;
    assign alu.carry = carry_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pc          <= '0;
            carry_q     <= 1'b0;
            sdr1_q      <= 1'b0;
            sdr2_q      <= 1'b0;
            o_imem_rd   <= 1'b0;
            o_imem_addr <= '0;
            alu.valid   <= 1'b0;
            alu.insn    <= '0;
            alu.pc      <= '0;
            alu.r1data  <= '0;
            alu.r2data  <= '0;
        end else begin
            o_imem_rd <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        pc          <= i_start_pc;
                        carry_q     <= 1'b0;
                        o_imem_rd   <= 1'b1;
                        o_imem_addr <= i_start_pc;
                        state       <= ST_FETCH;
                    end
                end
                ST_FETCH: state <= ST_DECODE;
                ST_DECODE: begin
                    alu.insn   <= i_imem_data;
                    alu.pc     <= pc;
                    alu.r1data <= i_rf_r1data;
                    alu.r2data <= i_rf_r2data;
                    sdr1_q     <= dec_sdr1;
                    sdr2_q     <= dec_sdr2;
                    alu.valid  <= 1'b1;
                    state      <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (alu.ready) begin
                        pc        <= pc_next;
                        alu.valid <= 1'b0;
                        if (sdr1_q)
                            carry_q <= alu.r1data[0];
                        else if (sdr2_q)
                            carry_q <= alu.r2data[0];
                        if (i_halt) begin
                            state <= ST_IDLE;
                        end else begin
                            o_imem_rd   <= 1'b1;
                            o_imem_addr <= pc_next;
                            state       <= ST_FETCH;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
            // Redirect wins over halt/start; a concurrent handshake keeps its carry update.
            if (i_redirect) begin
                pc          <= i_redirect_pc;
                o_imem_rd   <= 1'b1;
                o_imem_addr <= i_redirect_pc;
                alu.valid   <= 1'b0;
                state       <= ST_FETCH;
            end
        end
    end
endmodule

// File: tb/tb_lc4_alu_issue.sv
// Directed bench for lc4_alu_issue with behavioural imem and register file.
module tb_lc4_alu_issue;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] start_pc;
    logic        halt;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [2:0]  rf_r1sel;
    logic [2:0]  rf_r2sel;
    logic [63:0] rf_r1data;
    logic [63:0] rf_r2data;

    logic [15:0] imem [65536];
    logic [63:0] rf [8];
    int n_checks = 0;
    int n_pass = 0;

    lc4_alu_issue_if #(.WORD_SIZE(64)) alu_bus ();

    lc4_alu_issue #(.WORD_SIZE(64)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (start),
        .i_start_pc    (start_pc),
        .i_halt        (halt),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_imem_rd     (imem_rd),
        .o_imem_addr   (imem_addr),
        .i_imem_data   (imem_data),
        .o_rf_r1sel    (rf_r1sel),
        .o_rf_r2sel    (rf_r2sel),
        .i_rf_r1data   (rf_r1data),
        .i_rf_r2data   (rf_r2data),
        .alu           (alu_bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (imem_rd) imem_data <= imem[imem_addr];

    always_comb begin
        rf_r1data = rf[rf_r1sel];
        rf_r2data = rf[rf_r2sel];
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; start_pc = '0; halt = 1'b0;
        redirect = 1'b0; redirect_pc = '0; alu_bus.ready = 1'b1; imem_data = '0;
        for (int i = 0; i < 8; i++) rf[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
        rf[0] = 64'h0000_0000_0000_0003;
        rf[1] = 64'h1111_2222_3333_4444;
        rf[3] = 64'hFFFF_0000_0000_0002;
        imem[16'h0200] = 16'h1443;
        imem[16'h0201] = 16'hD6AB;
        imem[16'h0202] = 16'h7A45;
        imem[16'h0300] = 16'h1218;
        imem[16'h0301] = 16'hA233;
        imem[16'h0302] = 16'h1443;
        imem[16'h8000] = 16'h1218;
        imem[16'hFFFF] = 16'h1443;
        imem[16'h0000] = 16'h1443;

        tick(); tick();
        check("rst_valid", 64'(alu_bus.valid), 64'd0);
        check("rst_rd", 64'(imem_rd), 64'd0);
        check("rst_addr", 64'(imem_addr), 64'd0);
        check("rst_insn", 64'(alu_bus.insn), 64'd0);
        check("rst_pc", 64'(alu_bus.pc), 64'd0);
        check("rst_r1", alu_bus.r1data, 64'd0);
        check("rst_carry", 64'(alu_bus.carry), 64'd0);
        rst_n = 1'b1;
        tick();

        // Start at 0200, one issue every three cycles
        start = 1'b1; start_pc = 16'h0200;
        tick(); start = 1'b0;
        check("f0_rd", 64'(imem_rd), 64'd1);
        check("f0_addr", 64'(imem_addr), 64'h0200);
        tick();
        check("add_r1sel", 64'(rf_r1sel), 64'd1);
        check("add_r2sel", 64'(rf_r2sel), 64'd3);
        check("d0_valid", 64'(alu_bus.valid), 64'd0);
        tick();
        check("i0_valid", 64'(alu_bus.valid), 64'd1);
        check("i0_pc", 64'(alu_bus.pc), 64'h0200);
        check("i0_insn", 64'(alu_bus.insn), 64'h1443);
        check("i0_r1", alu_bus.r1data, 64'h1111_2222_3333_4444);
        check("i0_r2", alu_bus.r2data, 64'hFFFF_0000_0000_0002);
        tick();
        check("f1_addr", 64'(imem_addr), 64'h0201);
        check("f1_rd", 64'(imem_rd), 64'd1);
        check("f1_valid", 64'(alu_bus.valid), 64'd0);
        tick();
        check("hic_r1sel", 64'(rf_r1sel), 64'd3);
        tick();
        check("i1_valid", 64'(alu_bus.valid), 64'd1);
        check("i1_insn", 64'(alu_bus.insn), 64'hD6AB);

        // Backpressure
        alu_bus.ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", 64'(alu_bus.valid), 64'd1);
            check("bp_insn", 64'(alu_bus.insn), 64'hD6AB);
            check("bp_pc", 64'(alu_bus.pc), 64'h0201);
            check("bp_rd", 64'(imem_rd), 64'd0);
        end
        alu_bus.ready = 1'b1;
        tick();
        check("bp_rel_addr", 64'(imem_addr), 64'h0202);
        check("bp_rel_valid", 64'(alu_bus.valid), 64'd0);
        tick();
        check("str_r1sel", 64'(rf_r1sel), 64'd1);
        check("str_r2sel", 64'(rf_r2sel), 64'd5);
        tick();
        check("i2_insn", 64'(alu_bus.insn), 64'h7A45);
        check("i2_pc", 64'(alu_bus.pc), 64'h0202);

        // Halt at handshake
        halt = 1'b1;
        tick(); halt = 1'b0;
        check("halt_valid", 64'(alu_bus.valid), 64'd0);
        check("halt_rd", 64'(imem_rd), 64'd0);
        tick();
        check("halt_rd2", 64'(imem_rd), 64'd0);

        // Carry chain SDR1 -> SDR2
        start = 1'b1; start_pc = 16'h0300;
        tick(); start = 1'b0;
        tick(); tick();
        check("sdr1_insn", 64'(alu_bus.insn), 64'h1218);
        check("sdr1_carry_pre", 64'(alu_bus.carry), 64'd0);
        tick();
        check("sdr1_carry_post", 64'(alu_bus.carry), 64'd1);
        check("sdr1_next_addr", 64'(imem_addr), 64'h0301);
        tick(); tick();
        check("sdr2_insn", 64'(alu_bus.insn), 64'hA233);
        check("sdr2_carry_issued", 64'(alu_bus.carry), 64'd1);
        tick();
        check("sdr2_carry_post", 64'(alu_bus.carry), 64'd0);
        check("sdr2_next_addr", 64'(imem_addr), 64'h0302);

        // Redirect in DECODE drops the bundle
        tick();
        redirect = 1'b1; redirect_pc = 16'h8000;
        tick(); redirect = 1'b0;
        check("rdd_rd", 64'(imem_rd), 64'd1);
        check("rdd_addr", 64'(imem_addr), 64'h8000);
        check("rdd_valid", 64'(alu_bus.valid), 64'd0);
        tick();
        check("rdd_valid2", 64'(alu_bus.valid), 64'd0);
        tick();
        check("rdd_i_valid", 64'(alu_bus.valid), 64'd1);
        check("rdd_i_pc", 64'(alu_bus.pc), 64'h8000);
        check("rdd_i_carry", 64'(alu_bus.carry), 64'd0);

        // Redirect concurrent with handshake
        redirect = 1'b1; redirect_pc = 16'h8000;
        tick(); redirect = 1'b0;
        check("rdh_carry", 64'(alu_bus.carry), 64'd1);
        check("rdh_addr", 64'(imem_addr), 64'h8000);
        check("rdh_rd", 64'(imem_rd), 64'd1);
        check("rdh_valid", 64'(alu_bus.valid), 64'd0);

        // Reset while in ISSUE
        tick(); tick();
        check("pre_rst_valid", 64'(alu_bus.valid), 64'd1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_valid", 64'(alu_bus.valid), 64'd0);
        check("mid_rst_carry", 64'(alu_bus.carry), 64'd0);
        check("mid_rst_insn", 64'(alu_bus.insn), 64'd0);
        check("mid_rst_rd", 64'(imem_rd), 64'd0);
        rst_n = 1'b1;
        tick();

        // PC wrap
        start = 1'b1; start_pc = 16'hFFFF;
        tick(); start = 1'b0;
        check("wrap_f_addr", 64'(imem_addr), 64'hFFFF);
        tick(); tick();
        check("wrap_i_pc", 64'(alu_bus.pc), 64'hFFFF);
        tick();
        check("wrap_next_addr", 64'(imem_addr), 64'h0000);
        check("wrap_next_rd", 64'(imem_rd), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
